bpb_update_queue: RTL and testbench

Commit-side writer for the branch prediction buffer. Accepts up to two resolved branches per cycle from the dual-issue commit stage, buffers them in order in a small FIFO, and drains one per cycle onto the BPB's single update port (`pc_commit`, `wen`, `destpc_commit`). It sits between commit and the BPB, so that a dual commit never loses a predictor update.

---
 rtl/bpb_update_queue_if.sv | 33 +++
 rtl/bpb_update_queue.sv | 90 +++++++++
 tb/tb_bpb_update_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bpb_update_queue_if.sv
// Shared types and the commit/BPB-side bus of the BPB update queue.
package bpb_update_queue_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t target;
    logic  taken;
  } bpb_result_t;
endpackage

interface bpb_update_queue_if #(parameter int DEPTH = 8);
  import bpb_update_queue_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic        [1:0] in_valid;
  word_t       [1:0] in_pc;
  bpb_result_t [1:0] in_result;
  logic              in_ready;
  logic              hold;
  word_t             pc_commit;
  bpb_result_t       destpc_commit;
  logic              wen;
  logic     [CW-1:0] count;
  logic              overflow;

  modport master (
    output in_valid, in_pc, in_result, hold,
    input  in_ready, pc_commit, destpc_commit, wen, count, overflow
  );
  modport slave (
    input  in_valid, in_pc, in_result, hold,
    output in_ready, pc_commit, destpc_commit, wen, count, overflow
  );
endinterface

// File: rtl/bpb_update_queue.sv
// Dual-commit to single-port BPB update FIFO; drains one entry per cycle in order.
module bpb_update_queue
  import bpb_update_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  bpb_update_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    word_t       pc;
    bpb_result_t res;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;

  entry_t [1:0]       slot_e;
  logic               rdy, pop;
  logic [1:0]         push;

  for (genvar k = 0; k < 2; k++) begin : g_slot
    assign slot_e[k] = {bus.in_pc[k], bus.in_result[k]};
  end

  // Handshake and head outputs, all derived from registered state (no bypass).
  always_comb begin
    rdy  = count_q <= CW'(DEPTH - 2);
    pop  = (count_q != '0) & ~bus.hold;
    push = bus.in_valid & {2{rdy}};
    bus.in_ready      = rdy;
    bus.wen           = pop;
    bus.count         = count_q;
    bus.overflow      = ovf_q;
    bus.pc_commit     = '0;
    bus.destpc_commit = '0;
    if (count_q != '0) begin
      bus.pc_commit     = mem_q[head_q].pc;
      bus.destpc_commit = mem_q[head_q].res;
    end
  end

  // Next state: slot 0 lands at tail, slot 1 behind it; pointers wrap mod DEPTH.
  always_comb begin
    mem_d   = mem_q;
    tail_d  = tail_q;
    head_d  = head_q + AW'(pop);
    unique case (push)
      2'b11: begin
        mem_d[tail_q]          = slot_e[0];
        mem_d[tail_q + AW'(1)] = slot_e[1];
        tail_d                 = tail_q + AW'(2);
      end
      2'b01: begin
        mem_d[tail_q] = slot_e[0];
        tail_d        = tail_q + AW'(1);
      end
      2'b10: begin
        mem_d[tail_q] = slot_e[1];
        tail_d        = tail_q + AW'(1);
      end
      default: ;
    endcase
    count_d = count_q + CW'(push[0]) + CW'(push[1]) - CW'(pop);
    ovf_d   = ovf_q | ((|bus.in_valid) & ~rdy);
  end

  // State registers; reset drops count so wen falls immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_bpb_update_queue.sv
// Scoreboard bench for bpb_update_queue: driver models occupancy, monitor checks BPB writes.
module tb_bpb_update_queue;
  import bpb_update_queue_pkg::*;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bpb_update_queue_if #(.DEPTH(DEPTH)) bus();
  bpb_update_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [64:0] sb[$];
  int   m_cnt = 0;
  logic m_ovf = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_rdy();
    return (DEPTH - m_cnt) >= 2;
  endfunction

  // One clock of stimulus; checks registered-state outputs against the model.
  task automatic cycle(input logic [1:0] v, input word_t p0, input bpb_result_t r0,
                       input word_t p1, input bpb_result_t r1, input logic h);
    logic rdy, pop;
    int   np;
    @(posedge clk); #1;
    bus.in_valid     = v;
    bus.in_pc[0]     = p0;
    bus.in_result[0] = r0;
    bus.in_pc[1]     = p1;
    bus.in_result[1] = r1;
    bus.hold         = h;
    #1;
    rdy = model_rdy();
    pop = (m_cnt != 0) && !h;
    chk("count", 65'(bus.count), 65'(m_cnt));
    chk("in_ready", 65'(bus.in_ready), 65'(rdy));
    chk("wen", 65'(bus.wen), 65'(pop));
    chk("overflow", 65'(bus.overflow), 65'(m_ovf));
    if (m_cnt == 0) chk("idle_outputs", {bus.pc_commit, bus.destpc_commit}, 65'd0);
    np = 0;
    if (v != 2'b00 && !rdy) m_ovf = 1'b1;
    else begin
      if (v[0]) begin sb.push_back({p0, r0}); np++; end
      if (v[1]) begin sb.push_back({p1, r1}); np++; end
    end
    m_cnt = m_cnt + np - (pop ? 1 : 0);
  endtask

  task automatic idle(input logic h);
    cycle(2'b00, '0, '0, '0, '0, h);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_cnt != 0; i++) idle(1'b0);
    chk("drain_bound", 65'(m_cnt), 65'd0);
    idle(1'b0);
    chk("sb_empty", 65'(sb.size()), 65'd0);
  endtask

  // Monitor: every BPB write must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (reset && bus.wen) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wr_unexpected: pc %h with empty scoreboard at %0t", bus.pc_commit, $time);
      end else begin
        logic [64:0] e;
        e = sb.pop_front();
        chk("bpb_write", {bus.pc_commit, bus.destpc_commit}, e);
      end
    end
  end

  initial begin
    int n_dual;
    bus.in_valid = '0; bus.in_pc = '0; bus.in_result = '0; bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // idle after reset
    repeat (10) idle(1'b0);

    // single push on slot 1
    cycle(2'b10, '0, '0, 32'hBFC00010, {32'h0, 1'b1}, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // sustained dual push from 0x100
    n_dual = 0;
    for (int i = 0; i < 20 && model_rdy(); i++) begin
      cycle(2'b11, 32'h100 + 8*i, {32'h1000 + 8*i, 1'b1},
            32'h104 + 8*i, {32'h1004 + 8*i, 1'b0}, 1'b0);
      n_dual++;
    end
    chk("dual_cycles", 65'(n_dual), 65'd6);
    drain();

    // hold with three entries queued
    cycle(2'b11, 32'h200, {32'h300, 1'b1}, 32'h204, {32'h304, 1'b0}, 1'b1);
    cycle(2'b01, 32'h208, {32'h308, 1'b1}, '0, '0, 1'b1);
    repeat (3) idle(1'b1);
    drain();

    // overflow while full
    for (int i = 0; i < 6 && model_rdy(); i++)
      cycle(2'b11, 32'h400 + 8*i, {32'h0, 1'b0}, 32'h404 + 8*i, {32'h0, 1'b1}, 1'b1);
    repeat (2) cycle(2'b11, 32'hDEAD0000, {32'h0, 1'b1}, 32'hDEAD0004, {32'h0, 1'b1}, 1'b1);
    idle(1'b1);
    drain();

    // reset mid-operation with 5 entries
    cycle(2'b11, 32'h500, {32'h1, 1'b1}, 32'h504, {32'h2, 1'b0}, 1'b1);
    cycle(2'b11, 32'h508, {32'h3, 1'b1}, 32'h50C, {32'h4, 1'b0}, 1'b1);
    cycle(2'b01, 32'h510, {32'h5, 1'b1}, '0, '0, 1'b1);
    @(posedge clk); #1;
    chk("pre_reset_count", 65'(bus.count), 65'(m_cnt));
    reset = 1'b0; bus.hold = 1'b0; bus.in_valid = '0;
    #1;
    chk("rst_wen", 65'(bus.wen), 65'd0);
    chk("rst_count", 65'(bus.count), 65'd0);
    chk("rst_ready", 65'(bus.in_ready), 65'd1);
    chk("rst_ovf", 65'(bus.overflow), 65'd0);
    sb.delete(); m_cnt = 0; m_ovf = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    cycle(2'b01, 32'h600, {32'h700, 1'b1}, '0, '0, 1'b0);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] v;
      v = model_rdy() ? 2'($urandom_range(3)) : 2'b00;
      cycle(v, $urandom, {32'($urandom), 1'($urandom)},
            $urandom, {32'($urandom), 1'($urandom)}, $urandom_range(3) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
